// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared FSM state codes and init fill value for ram_access_ctrl
package ram_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_INIT  = 3'd0;
  localparam state_t S_IDLE  = 3'd1;
  localparam state_t S_WRITE = 3'd2;
  localparam state_t S_READ  = 3'd3;
  localparam state_t S_CAPT  = 3'd4;
  localparam state_t S_RESP  = 3'd5;

  localparam int INIT_VALUE = 0;

endpackage

// File: rtl/ram_init_seq.sv
// rtl/ram_init_seq.sv - post-reset clear sweep address counter (used only with RAM_CTRL_INIT_EN)
module ram_init_seq
  import ram_ctrl_pkg::*;
#(
  parameter int addr_size = 4,
  parameter int mem_depth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [addr_size-1:0] addr,
  output logic                 done
);

  localparam logic [addr_size-1:0] LAST = addr_size'(mem_depth - 1);

  logic [addr_size-1:0] cnt_q, cnt_d;

  // done flags the final address; the counter parks there until the next reset
  assign done = (cnt_q == LAST);
  assign addr = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en && !done) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - request/response sequencer for single_port_ram; RAM_CTRL_INIT_EN adds a post-reset clear sweep
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_size  = 4,
  parameter int mem_depth  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [addr_size-1:0]  req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_wr_rd,
  output logic                  ram_out_en,
  output logic [addr_size-1:0]  ram_address,
  output logic [data_width-1:0] ram_data_in,
  input  logic [data_width-1:0] ram_data_out
);

  localparam logic [addr_size:0] DEPTH = (addr_size + 1)'(mem_depth);

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  in_range_q, in_range_d;
  logic [data_width-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  ram_cs_q, ram_cs_d;
  logic                  ram_wr_rd_q, ram_wr_rd_d;
  logic                  ram_out_en_q, ram_out_en_d;
  logic [addr_size-1:0]  ram_address_q, ram_address_d;
  logic [data_width-1:0] ram_data_in_q, ram_data_in_d;
  logic                  req_in_range;

  assign req_in_range = ({1'b0, req_addr} < DEPTH);

`ifdef RAM_CTRL_INIT_EN
  logic                 init_en;
  logic [addr_size-1:0] init_addr;
  logic                 init_done;
  logic                 busy_q, busy_d;

  ram_init_seq #(
    .addr_size (addr_size),
    .mem_depth (mem_depth)
  ) u_init_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (init_en),
    .addr  (init_addr),
    .done  (init_done)
  );

  assign init_en = (state_q == S_INIT);
  assign busy_d  = (state_q == S_INIT);
  assign busy    = busy_q;
`else
  assign busy = 1'b0;
`endif

  // ram_* pins are registered, so each state computes the pins for the following cycle
  always_comb begin
    state_d       = state_q;
    in_range_d    = in_range_q;
    rsp_rdata_d   = rsp_rdata_q;
    ram_cs_d      = 1'b0;
    ram_wr_rd_d   = 1'b0;
    ram_out_en_d  = 1'b0;
    ram_address_d = ram_address_q;
    ram_data_in_d = ram_data_in_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          in_range_d    = req_in_range;
          ram_address_d = req_addr;
          ram_data_in_d = req_wdata;
          ram_cs_d      = req_in_range;
          ram_wr_rd_d   = req_wr;
          ram_out_en_d  = !req_wr && req_in_range;
          state_d       = req_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ: begin
        ram_cs_d     = in_range_q;
        ram_out_en_d = in_range_q;
        state_d      = S_CAPT;
      end
      S_CAPT: begin
        rsp_rdata_d = in_range_q ? ram_data_out : '0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
`ifdef RAM_CTRL_INIT_EN
      S_INIT: begin
        ram_cs_d      = 1'b1;
        ram_wr_rd_d   = 1'b1;
        ram_address_d = init_addr;
        ram_data_in_d = data_width'(INIT_VALUE);
        if (init_done) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // the last sweep write is still on the pins during the first IDLE cycle
    req_ready_d = (state_d == S_IDLE) && (state_q != S_INIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef RAM_CTRL_INIT_EN
      state_q <= S_INIT;
      busy_q  <= 1'b0;
`else
      state_q <= S_IDLE;
`endif
      req_ready_q   <= 1'b0;
      in_range_q    <= 1'b0;
      rsp_rdata_q   <= '0;
      ram_cs_q      <= 1'b0;
      ram_wr_rd_q   <= 1'b0;
      ram_out_en_q  <= 1'b0;
      ram_address_q <= '0;
      ram_data_in_q <= '0;
    end else begin
`ifdef RAM_CTRL_INIT_EN
      busy_q <= busy_d;
`endif
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      in_range_q    <= in_range_d;
      rsp_rdata_q   <= rsp_rdata_d;
      ram_cs_q      <= ram_cs_d;
      ram_wr_rd_q   <= ram_wr_rd_d;
      ram_out_en_q  <= ram_out_en_d;
      ram_address_q <= ram_address_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign ram_cs      = ram_cs_q;
  assign ram_wr_rd   = ram_wr_rd_q;
  assign ram_out_en  = ram_out_en_q;
  assign ram_address = ram_address_q;
  assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - scoreboard bench for ram_access_ctrl (depth 16 and depth 12 instances in lockstep)
module tb_ram_access_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_wr, rsp_ready;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;

  logic       req_ready16, rsp_valid16, busy16, cs16, wr16, oe16;
  logic [7:0] rdata16, di16, dout16;
  logic [3:0] a16;
  logic       req_ready12, rsp_valid12, busy12, cs12, wr12, oe12;
  logic [7:0] rdata12, di12, dout12;
  logic [3:0] a12;

  logic [7:0] mem16 [16];
  logic [7:0] mem12 [16];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int oor_cs = 0;
  bit seen   = 1'b0;
  logic [7:0] q16 [$];
  logic [7:0] q12 [$];
  int         qacc [$];

  always #5 clk = ~clk;

  ram_access_ctrl #(.data_width(8), .addr_size(4), .mem_depth(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready16),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid16), .rsp_ready(rsp_ready), .rsp_rdata(rdata16), .busy(busy16),
    .ram_cs(cs16), .ram_wr_rd(wr16), .ram_out_en(oe16),
    .ram_address(a16), .ram_data_in(di16), .ram_data_out(dout16)
  );

  ram_access_ctrl #(.data_width(8), .addr_size(4), .mem_depth(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready12),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid12), .rsp_ready(rsp_ready), .rsp_rdata(rdata12), .busy(busy12),
    .ram_cs(cs12), .ram_wr_rd(wr12), .ram_out_en(oe12),
    .ram_address(a12), .ram_data_in(di12), .ram_data_out(dout12)
  );

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem16[i] = 8'hEE;
      mem12[i] = 8'hEE;
    end
    dout16 = 8'h00;
    dout12 = 8'h00;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cs16) begin
      if (wr16) mem16[a16] <= di16;
      else if (oe16) dout16 <= mem16[a16];
    end
    if (cs12) begin
      if (wr12) mem12[a12] <= di12;
      else if (oe12) dout12 <= mem12[a12];
      if (a12 >= 4'd12) oor_cs <= oor_cs + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid16) begin
        if (!seen) begin
          seen = 1'b1;
          if (qacc.size() > 0) chk("rsp16 latency", 32'(cyc - qacc.pop_front()), 32'd3);
        end
        if (q16.size() == 0) chk("rsp16 unexpected", 32'(rsp_valid16), 32'd0);
        else begin
          chk("rsp16 rdata", 32'(rdata16), 32'(q16[0]));
          if (!rsp_ready) chk("req_ready during resp", 32'(req_ready16), 32'd0);
          else begin
            void'(q16.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (rsp_valid12) begin
        if (q12.size() == 0) chk("rsp12 unexpected", 32'(rsp_valid12), 32'd0);
        else begin
          chk("rsp12 rdata", 32'(rdata12), 32'(q12[0]));
          if (rsp_ready) void'(q12.pop_front());
        end
      end
    end
  end

  task automatic issue(input bit wr, input int a, input int d, input bit push,
                       input int e16, input int e12, output int waited);
    waited = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = 4'(a);
    req_wdata = 8'(d);
    @(negedge clk);
    while (!req_ready16 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready16) chk("req accept timeout", 32'(req_ready16), 32'd1);
    else if (!wr && push) begin
      q16.push_back(8'(e16));
      q12.push_back(8'(e12));
      qacc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q16.size() > 0 || q12.size() > 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain queues empty", 32'(q16.size() + q12.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready16), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid16), 32'd0);
    chk("reset rsp_rdata", 32'(rdata16), 32'd0);
    chk("reset busy", 32'(busy16), 32'd0);
    chk("reset ram ctrl", 32'({cs16, wr16, oe16}), 32'd0);
    chk("reset ram addr/data", 32'({a16, di16}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    issue(1, 0,  'h37, 0, 0, 0, w);
    issue(1, 4,  'h88, 0, 0, 0, w);
    issue(1, 7,  'h55, 0, 0, 0, w);
    issue(1, 13, 'h5A, 0, 0, 0, w);
    issue(0, 0,  0, 1, 'h37, 'h37, w);
    issue(0, 4,  0, 1, 'h88, 'h88, w);
    issue(0, 7,  0, 1, 'h55, 'h55, w);
    issue(0, 13, 0, 1, 'h5A, 'h00, w);
    drain();

    rsp_ready = 1'b0;
    issue(0, 4, 0, 1, 'h88, 'h88, w);
    n = 0;
    @(negedge clk);
    while (!rsp_valid16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall rsp_valid", 32'(rsp_valid16), 32'd1);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(0, 0, 0, 1, 'h37, 'h37, w);
    chk("accept right after resp", 32'(w), 32'd0);
    drain();

    req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd1; req_wdata = 8'h11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b req_ready", 32'(req_ready16), 32'(i % 2 == 0));
      chk("b2b ram_cs", 32'(cs16), 32'(i % 2 == 1));
      @(posedge clk);
      #1;
      if (i == 0) begin
        req_addr = 4'd2;
        req_wdata = 8'h22;
      end
      if (i == 2) req_valid = 1'b0;
    end
    issue(0, 1, 0, 1, 'h11, 'h11, w);
    issue(0, 2, 0, 1, 'h22, 'h22, w);
    drain();

    issue(0, 0, 0, 0, 0, 0, w);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid reset rsp_valid", 32'(rsp_valid16), 32'd0);
    chk("mid reset ram ctrl 16", 32'({cs16, wr16, oe16}), 32'd0);
    chk("mid reset ram ctrl 12", 32'({cs12, wr12, oe12}), 32'd0);
    chk("mid reset req_ready", 32'(req_ready16), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue(1, 3, 'h66, 0, 0, 0, w);
    issue(0, 3, 0, 1, 'h66, 'h66, w);
    drain();

`ifdef RAM_CTRL_INIT_EN
    issue(1, 15, 'hFF, 0, 0, 0, w);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy16) n++;
      else if (n > 0) break;
    end
    chk("init busy cycles", 32'(n), 32'd16);
    @(posedge clk);
    #1;
    issue(0, 15, 0, 1, 'h00, 'h00, w);
    drain();
`endif

    chk("out-of-range ram_cs pulses", 32'(oor_cs), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
